// File: rtl/tlb_maint_unit_pkg.sv
// Shared TLB maintenance types: op codes, entry layout and CSR field positions.
// Imported by the interface, the match helper and the maintenance unit top.
package tlb_maint_unit_pkg;

    localparam int TLBNUM     = 16;
    localparam int TLBNUMSIZE = $clog2(TLBNUM);

    typedef enum logic [2:0] {
        TLB_NOP  = 3'd0,
        TLB_SRCH = 3'd1,
        TLB_RD   = 3'd2,
        TLB_WR   = 3'd3,
        TLB_FILL = 3'd4,
        TLB_INV  = 3'd5
    } tlb_op_e;

    typedef enum logic [4:0] {
        INV_ALL0     = 5'd0,
        INV_ALL1     = 5'd1,
        INV_GLOBAL   = 5'd2,
        INV_LOCAL    = 5'd3,
        INV_ASID     = 5'd4,
        INV_ASID_VA  = 5'd5,
        INV_GASID_VA = 5'd6
    } flush_op_e;

    localparam logic [5:0] PS_4K      = 6'd12;
    localparam logic [5:0] PS_2M      = 6'd21;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam int ELO_V      = 0;
    localparam int ELO_D      = 1;
    localparam int ELO_PLV_LO = 2;
    localparam int ELO_MAT_LO = 4;
    localparam int ELO_G      = 6;
    localparam int ELO_PPN_LO = 8;
    localparam int IDX_PS_LO  = 24;
    localparam int IDX_NE     = 31;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } phytran_item_t;

    typedef struct packed {
        logic          e;
        logic          g;
        logic [9:0]    asid;
        logic [5:0]    ps;
        logic [18:0]   vppn;
        phytran_item_t p0;
        phytran_item_t p1;
    } tlb_item_t;

    // Rebuilds the ELO CSR image; G comes from the entry, not the page half.
    function automatic logic [31:0] phy_to_elo(input phytran_item_t p, input logic g);
        return {4'b0, p.ppn, 1'b0, g, p.mat, p.plv, p.d, p.v};
    endfunction

endpackage

// File: rtl/tlb_maint_unit_if.sv
// Request/CSR/response bundle between the WB stage (master) and the TLB unit (slave).
interface tlb_maint_unit_if;
    import tlb_maint_unit_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    tlb_op_e               req_op;
    logic [4:0]            inv_op;
    logic [9:0]            inv_asid;
    logic [31:0]           inv_va;
    logic [31:0]           csr_tlbidx;
    logic [31:0]           csr_tlbehi;
    logic [31:0]           csr_tlbelo0;
    logic [31:0]           csr_tlbelo1;
    logic [31:0]           csr_asid;
    logic [5:0]            csr_ecode;
    logic                  resp_valid;
    tlb_op_e               resp_op;
    logic                  resp_err;
    logic                  resp_ne;
    logic [TLBNUMSIZE-1:0] resp_index;
    logic [5:0]            resp_ps;
    logic [31:0]           resp_tlbehi;
    logic [31:0]           resp_tlbelo0;
    logic [31:0]           resp_tlbelo1;
    logic [9:0]            resp_asid;

    modport master (
        output req_valid, req_op, inv_op, inv_asid, inv_va,
               csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid, csr_ecode,
        input  req_ready, resp_valid, resp_op, resp_err, resp_ne, resp_index, resp_ps,
               resp_tlbehi, resp_tlbelo0, resp_tlbelo1, resp_asid
    );

    modport slave (
        input  req_valid, req_op, inv_op, inv_asid, inv_va,
               csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid, csr_ecode,
        output req_ready, resp_valid, resp_op, resp_err, resp_ne, resp_index, resp_ps,
               resp_tlbehi, resp_tlbelo0, resp_tlbelo1, resp_asid
    );

endinterface

// File: rtl/tlb_match.sv
// Combinational compare of one TLB entry against an ASID/VPPN pair.
// ignore_va lets the INVTLB ASID-only sweep reuse the same comparator.
module tlb_match
    import tlb_maint_unit_pkg::*;
(
    input  tlb_item_t   entry,
    input  logic [9:0]  asid,
    input  logic [18:0] vppn,
    input  logic        ignore_va,
    output logic        hit
);
    logic asid_eq;
    logic vppn_eq;

    assign asid_eq = (entry.asid == asid);
    assign vppn_eq = ignore_va |
                     ((entry.ps == PS_2M) ? (entry.vppn[18:9] == vppn[18:9])
                                          : (entry.vppn == vppn));
    assign hit     = entry.e & (entry.g | asid_eq) & vppn_eq;
endmodule

// File: rtl/tlb_maint_unit.sv
// TLB entry array plus TLBSRCH/RD/WR/FILL responder and the multi-cycle INVTLB sweep.
module tlb_maint_unit
    import tlb_maint_unit_pkg::*;
(
    input  logic aclk,
    input  logic areset,
    tlb_maint_unit_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_e;

    state_e                state_reg;
    tlb_item_t             entry_reg [TLBNUM];
    logic [TLBNUMSIZE-1:0] fill_cnt_reg;
    logic [TLBNUMSIZE-1:0] sweep_idx_reg;
    logic [4:0]            inv_op_reg;
    logic [9:0]            inv_asid_reg;
    logic [18:0]           inv_vppn_reg;

    logic [9:0]            csr_asid;
    logic [18:0]           csr_vppn;
    logic [TLBNUMSIZE-1:0] rd_idx;
    logic                  accept;
    tlb_item_t             rd_entry;
    tlb_item_t             wr_entry;
    tlb_item_t             sweep_entry;
    logic [TLBNUM-1:0]     srch_hit;
    logic                  srch_any;
    logic [TLBNUMSIZE-1:0] srch_index;
    logic                  inv_hit;
    logic                  inv_clear;
    logic                  unused_bits;

    assign csr_asid    = bus.csr_asid[9:0];
    assign csr_vppn    = bus.csr_tlbehi[31:13];
    assign rd_idx      = bus.csr_tlbidx[TLBNUMSIZE-1:0];
    assign accept      = bus.req_valid & bus.req_ready & (bus.req_op != TLB_NOP);
    assign rd_entry    = entry_reg[rd_idx];
    assign sweep_entry = entry_reg[sweep_idx_reg];
    assign unused_bits = ^{bus.csr_asid[31:10], bus.csr_tlbehi[12:0], bus.csr_tlbidx[30],
                           bus.csr_tlbidx[23:TLBNUMSIZE], bus.inv_va[12:0],
                           bus.csr_tlbelo0[31:28], bus.csr_tlbelo0[7],
                           bus.csr_tlbelo1[31:28], bus.csr_tlbelo1[7]};

    generate
        for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_srch
            tlb_match u_match (
                .entry    (entry_reg[gi]),
                .asid     (csr_asid),
                .vppn     (csr_vppn),
                .ignore_va(1'b0),
                .hit      (srch_hit[gi])
            );
        end
    endgenerate

    tlb_match u_inv_match (
        .entry    (sweep_entry),
        .asid     (inv_asid_reg),
        .vppn     (inv_vppn_reg),
        .ignore_va(inv_op_reg == INV_ASID),
        .hit      (inv_hit)
    );

    // Walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        srch_any   = 1'b0;
        srch_index = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (srch_hit[i]) begin
                srch_any   = 1'b1;
                srch_index = TLBNUMSIZE'(i);
            end
        end
    end

    always_comb begin
        wr_entry      = '0;
        wr_entry.e    = (bus.csr_ecode == ECODE_TLBR) | ~bus.csr_tlbidx[IDX_NE];
        wr_entry.g    = bus.csr_tlbelo0[ELO_G] & bus.csr_tlbelo1[ELO_G];
        wr_entry.asid = csr_asid;
        wr_entry.ps   = bus.csr_tlbidx[IDX_PS_LO +: 6];
        wr_entry.vppn = csr_vppn;
        wr_entry.p0   = '{ppn: bus.csr_tlbelo0[ELO_PPN_LO +: 20], plv: bus.csr_tlbelo0[ELO_PLV_LO +: 2],
                          mat: bus.csr_tlbelo0[ELO_MAT_LO +: 2], d: bus.csr_tlbelo0[ELO_D],
                          v: bus.csr_tlbelo0[ELO_V]};
        wr_entry.p1   = '{ppn: bus.csr_tlbelo1[ELO_PPN_LO +: 20], plv: bus.csr_tlbelo1[ELO_PLV_LO +: 2],
                          mat: bus.csr_tlbelo1[ELO_MAT_LO +: 2], d: bus.csr_tlbelo1[ELO_D],
                          v: bus.csr_tlbelo1[ELO_V]};
    end

    always_comb begin
        inv_clear = 1'b0;
        case (inv_op_reg)
            INV_ALL0, INV_ALL1:    inv_clear = 1'b1;
            INV_GLOBAL:            inv_clear = sweep_entry.g;
            INV_LOCAL:             inv_clear = ~sweep_entry.g;
            INV_ASID, INV_ASID_VA: inv_clear = ~sweep_entry.g & inv_hit;
            INV_GASID_VA:          inv_clear = inv_hit;
            default:               inv_clear = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg        <= ST_IDLE;
            fill_cnt_reg     <= '0;
            sweep_idx_reg    <= '0;
            inv_op_reg       <= '0;
            inv_asid_reg     <= '0;
            inv_vppn_reg     <= '0;
            bus.req_ready    <= 1'b1;
            bus.resp_valid   <= 1'b0;
            bus.resp_op      <= TLB_NOP;
            bus.resp_err     <= 1'b0;
            bus.resp_ne      <= 1'b0;
            bus.resp_index   <= '0;
            bus.resp_ps      <= '0;
            bus.resp_tlbehi  <= '0;
            bus.resp_tlbelo0 <= '0;
            bus.resp_tlbelo1 <= '0;
            bus.resp_asid    <= '0;
            for (int i = 0; i < TLBNUM; i++) begin
                entry_reg[i].e <= 1'b0;
            end
        end else begin
            fill_cnt_reg   <= (fill_cnt_reg == TLBNUMSIZE'(TLBNUM - 1)) ? '0 : fill_cnt_reg + 1'b1;
            bus.resp_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        case (bus.req_op)
                            TLB_SRCH: begin
                                bus.resp_valid <= 1'b1;
                                bus.resp_op    <= TLB_SRCH;
                                bus.resp_err   <= 1'b0;
                                bus.resp_ne    <= ~srch_any;
                                bus.resp_index <= srch_index;
                            end
                            TLB_RD: begin
                                bus.resp_valid   <= 1'b1;
                                bus.resp_op      <= TLB_RD;
                                bus.resp_err     <= 1'b0;
                                bus.resp_ne      <= ~rd_entry.e;
                                bus.resp_ps      <= rd_entry.e ? rd_entry.ps : 6'd0;
                                bus.resp_tlbehi  <= rd_entry.e ? {rd_entry.vppn, 13'b0} : 32'd0;
                                bus.resp_tlbelo0 <= rd_entry.e ? phy_to_elo(rd_entry.p0, rd_entry.g) : 32'd0;
                                bus.resp_tlbelo1 <= rd_entry.e ? phy_to_elo(rd_entry.p1, rd_entry.g) : 32'd0;
                                bus.resp_asid    <= rd_entry.e ? rd_entry.asid : 10'd0;
                            end
                            TLB_WR, TLB_FILL: begin
                                entry_reg[(bus.req_op == TLB_WR) ? rd_idx : fill_cnt_reg] <= wr_entry;
                                bus.resp_valid <= 1'b1;
                                bus.resp_op    <= bus.req_op;
                                bus.resp_err   <= 1'b0;
                                bus.resp_ne    <= 1'b0;
                            end
                            TLB_INV: begin
                                if (bus.inv_op > INV_GASID_VA) begin
                                    bus.resp_valid <= 1'b1;
                                    bus.resp_op    <= TLB_INV;
                                    bus.resp_err   <= 1'b1;
                                    bus.resp_ne    <= 1'b0;
                                end else begin
                                    state_reg     <= ST_SWEEP;
                                    bus.req_ready <= 1'b0;
                                    sweep_idx_reg <= '0;
                                    inv_op_reg    <= bus.inv_op;
                                    inv_asid_reg  <= bus.inv_asid;
                                    inv_vppn_reg  <= bus.inv_va[31:13];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_SWEEP: begin
                    if (inv_clear) begin
                        entry_reg[sweep_idx_reg].e <= 1'b0;
                    end
                    if (sweep_idx_reg == TLBNUMSIZE'(TLBNUM - 1)) begin
                        state_reg <= ST_DONE;
                    end else begin
                        sweep_idx_reg <= sweep_idx_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg      <= ST_IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b1;
                    bus.resp_op    <= TLB_INV;
                    bus.resp_err   <= 1'b0;
                    bus.resp_ne    <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_maint_unit.sv
// Directed bench for tlb_maint_unit: vector table for single-cycle ops, hand sequences for FILL/INVTLB/reset.
module tb_tlb_maint_unit;
    import tlb_maint_unit_pkg::*;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    tlb_maint_unit_if bus();

    tlb_maint_unit dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference copy of the free-running fill counter.
    int unsigned fill_model;
    always @(posedge aclk or posedge areset) begin
        if (areset) fill_model <= 0;
        else        fill_model <= (fill_model + 1) % TLBNUM;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] idx, ehi, elo0, elo1;
        logic [9:0]  asid;
        logic [5:0]  ecode;
        logic        x_ne;
        logic [3:0]  x_index;
        logic [5:0]  x_ps;
        logic [31:0] x_ehi, x_elo0, x_elo1;
        logic [9:0]  x_asid;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t v_wr(input logic [31:0] idx, input logic [31:0] ehi, input logic [31:0] elo0,
                                  input logic [31:0] elo1, input logic [9:0] asid, input logic [5:0] ecode);
        vec_t v = '{default: '0};
        v.op = 3'(TLB_WR); v.idx = idx; v.ehi = ehi; v.elo0 = elo0; v.elo1 = elo1; v.asid = asid; v.ecode = ecode;
        return v;
    endfunction

    function automatic vec_t v_srch(input logic [31:0] ehi, input logic [9:0] asid, input logic ne, input logic [3:0] index);
        vec_t v = '{default: '0};
        v.op = 3'(TLB_SRCH); v.ehi = ehi; v.asid = asid; v.x_ne = ne; v.x_index = index;
        return v;
    endfunction

    function automatic vec_t v_rd(input logic [31:0] idx, input logic ne, input logic [5:0] ps, input logic [31:0] ehi,
                                  input logic [31:0] elo0, input logic [31:0] elo1, input logic [9:0] asid);
        vec_t v = '{default: '0};
        v.op = 3'(TLB_RD); v.idx = idx; v.x_ne = ne; v.x_ps = ps; v.x_ehi = ehi;
        v.x_elo0 = elo0; v.x_elo1 = elo1; v.x_asid = asid;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] idx, input logic [31:0] ehi, input logic [31:0] elo0,
                         input logic [31:0] elo1, input logic [9:0] asid, input logic [5:0] ecode);
        bus.req_op      = tlb_op_e'(op);
        bus.csr_tlbidx  = idx;
        bus.csr_tlbehi  = ehi;
        bus.csr_tlbelo0 = elo0;
        bus.csr_tlbelo1 = elo1;
        bus.csr_asid    = {22'd0, asid};
        bus.csr_ecode   = ecode;
        bus.req_valid   = 1'b1;
        $display("txn op=%0d idx=%08h ehi=%08h elo0=%08h elo1=%08h asid=%0d ecode=%02h",
                 op, idx, ehi, elo0, elo1, asid, ecode);
        @(negedge aclk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drive_inv(input logic [4:0] op, input logic [9:0] asid, input logic [31:0] va);
        bus.req_op    = TLB_INV;
        bus.inv_op    = op;
        bus.inv_asid  = asid;
        bus.inv_va    = va;
        bus.req_valid = 1'b1;
        $display("txn op=INV inv_op=%0d asid=%0d va=%08h", op, asid, va);
        @(negedge aclk);
        bus.req_valid = 1'b0;
    endtask

    task automatic rd_ne(input string name, input int idx, input logic exp_ne);
        drive(3'(TLB_RD), 32'(idx), 0, 0, 0, 0, 0);
        check({name, "_valid"}, bus.resp_valid, 1);
        check({name, "_ne"}, bus.resp_ne, exp_ne);
    endtask

    task automatic wait_sweep(input string name);
        int low  = 0;
        int seen = 0;
        while (bus.req_ready !== 1'b1 && low < 40) begin
            if (bus.resp_valid === 1'b1) seen++;
            low++;
            @(negedge aclk);
        end
        check({name, "_ready_low_cycles"}, low, 17);
        check({name, "_early_resp"}, seen, 0);
        check({name, "_resp_valid"}, bus.resp_valid, 1);
        check({name, "_resp_op"}, bus.resp_op, TLB_INV);
        check({name, "_resp_err"}, bus.resp_err, 0);
    endtask

    initial begin
        int fidx [4];
        int w;
        int seen;

        bus.req_valid = 0; bus.req_op = TLB_NOP; bus.inv_op = 0; bus.inv_asid = 0; bus.inv_va = 0;
        bus.csr_tlbidx = 0; bus.csr_tlbehi = 0; bus.csr_tlbelo0 = 0; bus.csr_tlbelo1 = 0;
        bus.csr_asid = 0; bus.csr_ecode = 0;

        vecs[0]  = v_rd(32'h0, 1, 0, 0, 0, 0, 0);
        vecs[1]  = v_srch(32'h2468A000, 10'd5, 1, 0);
        vecs[2]  = v_wr(32'h0C000003, 32'h2468A000, 32'h0ABCDE1F, 32'h01111141, 10'd5, 6'h00);
        vecs[3]  = v_srch(32'h2468A000, 10'd5, 0, 3);
        vecs[4]  = v_srch(32'h2468A000, 10'd6, 1, 0);
        vecs[5]  = v_rd(32'h3, 0, 6'd12, 32'h2468A000, 32'h0ABCDE1F, 32'h01111101, 10'd5);
        vecs[6]  = v_wr(32'h15000007, 32'h80000000, 32'h02222241, 32'h02222241, 10'd2, 6'h00);
        vecs[7]  = v_srch(32'h803FE000, 10'd9, 0, 7);
        vecs[8]  = v_srch(32'h80400000, 10'd9, 1, 0);
        vecs[9]  = v_rd(32'h7, 0, 6'd21, 32'h80000000, 32'h02222241, 32'h02222241, 10'd2);
        vecs[10] = v_wr(32'h8C000009, 32'h01578000, 32'h03333307, 32'h0, 10'd1, 6'h00);
        vecs[11] = v_rd(32'h9, 1, 0, 0, 0, 0, 0);
        vecs[12] = v_wr(32'h8C000009, 32'h01578000, 32'h03333307, 32'h0, 10'd1, 6'h3F);
        vecs[13] = v_rd(32'h9, 0, 6'd12, 32'h01578000, 32'h03333307, 32'h0, 10'd1);
        vecs[14] = v_srch(32'h01578000, 10'd1, 0, 9);
        vecs[15] = v_wr(32'h0C000002, 32'h01578000, 32'h0, 32'h0, 10'd1, 6'h00);
        vecs[16] = v_srch(32'h01578000, 10'd1, 0, 2);

        repeat (2) @(negedge aclk);
        areset = 1'b0;
        check("reset_req_ready", bus.req_ready, 1);
        check("reset_resp_valid", bus.resp_valid, 0);
        check("reset_resp_err", bus.resp_err, 0);
        check("reset_resp_index", 32'(bus.resp_index), 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].idx, vecs[i].ehi, vecs[i].elo0, vecs[i].elo1, vecs[i].asid, vecs[i].ecode);
            check($sformatf("v%0d_valid", i), bus.resp_valid, 1);
            check($sformatf("v%0d_op", i), 32'(bus.resp_op), 32'(vecs[i].op));
            check($sformatf("v%0d_err", i), bus.resp_err, 0);
            if (vecs[i].op == 3'(TLB_SRCH)) begin
                check($sformatf("v%0d_srch_ne", i), bus.resp_ne, vecs[i].x_ne);
                check($sformatf("v%0d_srch_index", i), 32'(bus.resp_index), 32'(vecs[i].x_index));
            end else if (vecs[i].op == 3'(TLB_RD)) begin
                check($sformatf("v%0d_rd_ne", i), bus.resp_ne, vecs[i].x_ne);
                check($sformatf("v%0d_rd_ps", i), 32'(bus.resp_ps), 32'(vecs[i].x_ps));
                check($sformatf("v%0d_rd_ehi", i), bus.resp_tlbehi, vecs[i].x_ehi);
                check($sformatf("v%0d_rd_elo0", i), bus.resp_tlbelo0, vecs[i].x_elo0);
                check($sformatf("v%0d_rd_elo1", i), bus.resp_tlbelo1, vecs[i].x_elo1);
                check($sformatf("v%0d_rd_asid", i), 32'(bus.resp_asid), 32'(vecs[i].x_asid));
            end
        end

        // FILL: first two land on counter 15 and its wrap to 0, the rest after idle gaps.
        w = 0;
        while (fill_model != 15 && w < 20) begin
            @(negedge aclk);
            w++;
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) repeat (3) @(negedge aclk);
            if (k == 3) repeat (6) @(negedge aclk);
            fidx[k] = int'(fill_model);
            drive(3'(TLB_FILL), 32'h0C000005, {19'h07000 + 19'(k), 13'b0}, 32'h41, 32'h41, 10'd0, 6'h00);
            check($sformatf("fill%0d_valid", k), bus.resp_valid, 1);
        end
        fidx[0] = 15;
        fidx[1] = 0;
        for (int k = 0; k < 4; k++) begin
            drive(3'(TLB_SRCH), 0, {19'h07000 + 19'(k), 13'b0}, 0, 0, 10'd7, 6'h00);
            check($sformatf("fill%0d_hit_ne", k), bus.resp_ne, 0);
            check($sformatf("fill%0d_index", k), 32'(bus.resp_index), 32'(fidx[k]));
        end

        // INVTLB op0 clears everything, then op4 asid 5 over a G/ASID mix.
        drive_inv(5'd0, 10'd0, 32'h0);
        wait_sweep("inv0");
        rd_ne("inv0_rd15", 15, 1);
        drive(3'(TLB_WR), 32'h0C000000, {19'h100, 13'b0}, 32'h01, 32'h01, 10'd5, 6'h00);
        drive(3'(TLB_WR), 32'h0C000001, {19'h101, 13'b0}, 32'h41, 32'h41, 10'd5, 6'h00);
        drive(3'(TLB_WR), 32'h0C000002, {19'h102, 13'b0}, 32'h01, 32'h01, 10'd6, 6'h00);
        drive(3'(TLB_WR), 32'h0C000003, {19'h103, 13'b0}, 32'h01, 32'h01, 10'd5, 6'h00);
        drive(3'(TLB_WR), 32'h0C000004, {19'h104, 13'b0}, 32'h41, 32'h41, 10'd6, 6'h00);
        drive_inv(5'd4, 10'd5, 32'h0);
        wait_sweep("inv4");
        rd_ne("inv4_rd0", 0, 1);
        rd_ne("inv4_rd1", 1, 0);
        rd_ne("inv4_rd2", 2, 0);
        rd_ne("inv4_rd3", 3, 1);
        rd_ne("inv4_rd4", 4, 0);

        // Illegal INVTLB op: immediate error, nothing cleared, no sweep.
        drive_inv(5'd7, 10'd6, 32'h0);
        check("inv7_valid", bus.resp_valid, 1);
        check("inv7_err", bus.resp_err, 1);
        check("inv7_op", bus.resp_op, TLB_INV);
        check("inv7_ready", bus.req_ready, 1);
        rd_ne("inv7_rd2", 2, 0);
        rd_ne("inv7_rd4", 4, 0);

        // Reset in the middle of a sweep: sweep aborted, array cleared, no response.
        drive(3'(TLB_WR), 32'h0C00000C, {19'h555, 13'b0}, 32'h01, 32'h01, 10'd3, 6'h00);
        rd_ne("rst_pre_rd12", 12, 0);
        drive_inv(5'd1, 10'd0, 32'h0);
        repeat (5) @(negedge aclk);
        check("rst_mid_ready_low", bus.req_ready, 0);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        check("rst_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus.resp_valid === 1'b1) seen++;
            @(negedge aclk);
        end
        check("rst_no_resp", seen, 0);
        rd_ne("rst_rd12", 12, 1);
        rd_ne("rst_rd2", 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
